// File: rtl/bp_profiler_pkg.sv
// Shared types for the profiler counter bank: the stall-reason list that
// sizes the default bank, and the read-port FSM state encoding.
// The BP_PROFILER_SATURATE_EN macro (saturate instead of wrap) is consumed
// by bp_profiler_counter.
package bp_profiler_pkg;

    typedef enum logic [4:0] {
        e_fe_queue_stall,
        e_fe_wait_stall,
        e_itlb_miss,
        e_icache_miss,
        e_icache_rollback,
        e_icache_fence,
        e_branch_override,
        e_ret_override,
        e_fe_cmd,
        e_fe_cmd_fence,
        e_mispredict,
        e_control_haz,
        e_long_haz,
        e_data_haz,
        e_aux_dep,
        e_load_dep,
        e_mul_dep,
        e_fma_dep,
        e_sb_iraw_dep,
        e_sb_fraw_dep,
        e_sb_iwaw_dep,
        e_sb_fwaw_dep,
        e_struct_haz,
        e_idiv_haz,
        e_fdiv_haz,
        e_ptw_busy,
        e_special,
        e_replay,
        e_exception,
        e_interrupt,
        e_unknown
    } bp_stall_reason_e;

    // Member count: the last enumerator must stay e_unknown for this to hold.
    localparam int bp_num_stall_reasons_gp = int'(e_unknown) + 32'sd1;

    typedef enum logic [0:0] {
        e_rd_idle = 1'b0,
        e_rd_resp = 1'b1
    } bp_rd_state_e;

endpackage

// File: rtl/bp_profiler_counter.sv
// Single profiler counter with increment, synchronous clear and a sticky
// overflow flag. Define BP_PROFILER_SATURATE_EN to saturate at all-ones;
// otherwise the counter wraps to zero.
module bp_profiler_counter #(
    parameter int width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               inc_i,
    input  logic               clear_i,
    output logic [width_p-1:0] count_o,
    output logic               overflow_o
);

    logic [width_p-1:0] count_d, count_q;
    logic               ovf_d, ovf_q;
    logic               all_ones_s;

    assign all_ones_s = &count_q;

    // Next-state: clear beats increment; overflow is sticky until clear.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (inc_i) begin
`ifdef BP_PROFILER_SATURATE_EN
            if (all_ones_s) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + width_p'(1'b1);
            end
`else
            count_d = count_q + width_p'(1'b1);
            if (all_ones_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
`endif
        end else begin
            count_d = count_q;
            ovf_d   = ovf_q;
        end
    end

    // Counter and overflow state.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/bp_profiler_counter_bank.sv
// Profiler counter bank: num_events_p event counters plus a cycle counter
// (highest index), a shadow bank loaded by snapshot_i, and a two-state read
// port that only ever returns shadow values. Saturation is selected by the
// BP_PROFILER_SATURATE_EN macro inside bp_profiler_counter.
module bp_profiler_counter_bank
    import bp_profiler_pkg::*;
#(
    parameter int num_events_p  = bp_num_stall_reasons_gp,
    parameter int width_p       = 64,
    parameter int addr_width_lp = $clog2(num_events_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     en_i,
    input  logic [num_events_p-1:0]  event_i,
    input  logic                     clear_i,
    input  logic                     snapshot_i,
    input  logic                     rd_v_i,
    input  logic [addr_width_lp-1:0] rd_addr_i,
    output logic                     rd_ready_and_o,
    output logic                     rd_data_v_o,
    output logic [width_p-1:0]       rd_data_o,
    input  logic                     rd_yumi_i,
    output logic [num_events_p:0]    overflow_o
);

    localparam int num_ctr_lp = num_events_p + 1;

    logic [num_events_p:0] inc_s;
    logic [width_p-1:0]    live_s   [num_ctr_lp];
    logic [width_p-1:0]    shadow_d [num_ctr_lp];
    logic [width_p-1:0]    shadow_q [num_ctr_lp];
    logic [width_p-1:0]    rd_sel_s;

    bp_rd_state_e          state_q;
    logic [width_p-1:0]    rd_data_q;
    logic                  rd_data_v_q;
    logic                  rd_ready_q;

    // Cycle counter sits at the top index and counts whenever enabled.
    assign inc_s = {en_i, event_i & {num_events_p{en_i}}};

    for (genvar g = 0; g < num_ctr_lp; g++) begin : g_ctr
        bp_profiler_counter #(.width_p(width_p)) u_ctr (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .inc_i      (inc_s[g]),
            .clear_i    (clear_i),
            .count_o    (live_s[g]),
            .overflow_o (overflow_o[g])
        );
    end

    // Snapshot captures the registered live values, i.e. pre-increment and pre-clear.
    always_comb begin
        shadow_d = shadow_q;
        if (snapshot_i) begin
            shadow_d = live_s;
        end else begin
            shadow_d = shadow_q;
        end
    end

    // Shadow bank storage.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < num_ctr_lp; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
        end
    end

    // Read mux over the shadow bank; unmatched (out-of-range) addresses give zero.
    always_comb begin
        rd_sel_s = '0;
        for (int i = 0; i < num_ctr_lp; i++) begin
            rd_sel_s = rd_sel_s
                     | ((rd_addr_i == addr_width_lp'(i)) ? shadow_q[i] : '0);
        end
    end

    // Read FSM: accept in IDLE, hold the response in RESP until consumed.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= e_rd_idle;
            rd_data_q   <= '0;
            rd_data_v_q <= 1'b0;
            rd_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                e_rd_idle: begin
                    if (rd_v_i) begin
                        state_q     <= e_rd_resp;
                        rd_data_q   <= rd_sel_s;
                        rd_data_v_q <= 1'b1;
                        rd_ready_q  <= 1'b0;
                    end
                end
                e_rd_resp: begin
                    if (rd_yumi_i) begin
                        state_q     <= e_rd_idle;
                        rd_data_v_q <= 1'b0;
                        rd_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= e_rd_idle;
                    rd_data_v_q <= 1'b0;
                    rd_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign rd_ready_and_o = rd_ready_q;
    assign rd_data_v_o    = rd_data_v_q;
    assign rd_data_o      = rd_data_q;

endmodule

// File: tb/tb_bp_profiler_counter_bank.sv
// Directed bench for bp_profiler_counter_bank (4 events, 4-bit counters).
// Read expectations go into a queue; a negedge monitor pops one per response.
module tb_bp_profiler_counter_bank;

    localparam int NE = 4;
    localparam int W  = 4;
    localparam int AW = 3;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          en_i;
    logic [NE-1:0] event_i;
    logic          clear_i;
    logic          snapshot_i;
    logic          rd_v_i;
    logic [AW-1:0] rd_addr_i;
    logic          rd_ready_and_o;
    logic          rd_data_v_o;
    logic [W-1:0]  rd_data_o;
    logic          rd_yumi_i;
    logic [NE:0]   overflow_o;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q [$];
    logic         prev_v = 1'b0;
    logic [W-1:0] held_data = '0;

    bp_profiler_counter_bank #(.num_events_p(NE), .width_p(W)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .en_i           (en_i),
        .event_i        (event_i),
        .clear_i        (clear_i),
        .snapshot_i     (snapshot_i),
        .rd_v_i         (rd_v_i),
        .rd_addr_i      (rd_addr_i),
        .rd_ready_and_o (rd_ready_and_o),
        .rd_data_v_o    (rd_data_v_o),
        .rd_data_o      (rd_data_o),
        .rd_yumi_i      (rd_yumi_i),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop on each new response, then require the data to stay put.
    always @(negedge clk_i) begin
        if (rd_data_v_o === 1'b1 && !prev_v) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %0h expected no response", rd_data_o);
            end else begin
                check("rd_data", rd_data_o, exp_q.pop_front());
            end
            held_data = rd_data_o;
        end else if (rd_data_v_o === 1'b1 && prev_v) begin
            check("rd_stable", rd_data_o, held_data);
        end
        prev_v = (rd_data_v_o === 1'b1);
    end

    task automatic run(input int n, input logic en, input logic [NE-1:0] ev);
        en_i = en; event_i = ev;
        repeat (n) @(negedge clk_i);
        en_i = 1'b0; event_i = '0;
    endtask

    task automatic snap();
        snapshot_i = 1'b1;
        @(negedge clk_i);
        snapshot_i = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [W-1:0] exp,
                           input int hold, input logic with_snap);
        int budget;
        budget = 0;
        while (rd_ready_and_o !== 1'b1 && budget < 20) begin
            @(negedge clk_i); budget++;
        end
        check("rd_ready_idle", rd_ready_and_o, 1);
        rd_v_i = 1'b1; rd_addr_i = addr; snapshot_i = with_snap;
        exp_q.push_back(exp);
        @(negedge clk_i);
        rd_v_i = 1'b0; snapshot_i = 1'b0;
        budget = 0;
        while (rd_data_v_o !== 1'b1 && budget < 20) begin
            @(negedge clk_i); budget++;
        end
        check("rd_valid_seen", rd_data_v_o, 1);
        for (int k = 0; k < hold; k++) begin
            check("resp_valid_hold", rd_data_v_o, 1);
            check("resp_ready_low", rd_ready_and_o, 0);
            @(negedge clk_i);
        end
        rd_yumi_i = 1'b1;
        @(negedge clk_i);
        rd_yumi_i = 1'b0;
        check("idle_ready_back", rd_ready_and_o, 1);
        check("idle_valid_drop", rd_data_v_o, 0);
    endtask

    initial begin
        logic [W-1:0] exp_wrap;
        reset_i = 1'b1; en_i = 1'b0; event_i = '0; clear_i = 1'b0;
        snapshot_i = 1'b0; rd_v_i = 1'b0; rd_addr_i = '0; rd_yumi_i = 1'b0;
        @(negedge clk_i);
        check("reset_ready", rd_ready_and_o, 1);
        check("reset_valid", rd_data_v_o, 0);
        check("reset_data", rd_data_o, 0);
        check("reset_ovf", overflow_o, 0);
        reset_i = 1'b0;
        @(negedge clk_i);

        // 15 increments of event 2, no overflow yet.
        run(15, 1'b1, 4'b0100);
        snap();
        check("ovf_after_15", overflow_o, 0);
        do_read(3'd2, 4'd15, 0, 1'b0);
        do_read(3'd4, 4'd15, 0, 1'b0);
        do_read(3'd0, 4'd0, 0, 1'b0);
        do_read(3'd6, 4'd0, 0, 1'b0);

        // Two more increments: 17 total on event 2 and on the cycle counter.
`ifdef BP_PROFILER_SATURATE_EN
        exp_wrap = 4'd15;
`else
        exp_wrap = 4'd1;
`endif
        run(2, 1'b1, 4'b0100);
        snap();
        check("ovf_after_17", overflow_o, 5'b10100);
        do_read(3'd2, exp_wrap, 0, 1'b0);
        do_read(3'd4, exp_wrap, 0, 1'b0);

        // Clear together with an event 0 strobe, then 3 enabled cycles.
        clear_i = 1'b1; en_i = 1'b1; event_i = 4'b0001;
        @(negedge clk_i);
        clear_i = 1'b0;
        check("ovf_after_clear", overflow_o, 0);
        run(3, 1'b1, 4'b0000);
        snap();
        do_read(3'd0, 4'd0, 0, 1'b0);
        do_read(3'd4, 4'd3, 0, 1'b0);
        do_read(3'd2, 4'd0, 0, 1'b0);

        // Multi-hot, a disabled strobe, then snapshot in an incrementing cycle.
        run(2, 1'b1, 4'b0111);
        run(1, 1'b0, 4'b1111);
        en_i = 1'b1; event_i = 4'b1000; snapshot_i = 1'b1;
        @(negedge clk_i);
        en_i = 1'b0; event_i = '0; snapshot_i = 1'b0;
        do_read(3'd1, 4'd2, 0, 1'b0);
        do_read(3'd3, 4'd0, 0, 1'b0);
        do_read(3'd4, 4'd5, 0, 1'b0);

        // Long backpressure, then a read racing a snapshot (old value wins).
        do_read(3'd1, 4'd2, 5, 1'b0);
        do_read(3'd3, 4'd0, 0, 1'b1);
        do_read(3'd3, 4'd1, 0, 1'b0);

        // Reset in the middle of a response.
        rd_v_i = 1'b1; rd_addr_i = 3'd4;
        exp_q.push_back(4'd6);
        @(negedge clk_i);
        rd_v_i = 1'b0;
        #2;
        check("resp_before_reset", rd_data_v_o, 1);
        reset_i = 1'b1;
        #1;
        check("reset_mid_valid", rd_data_v_o, 0);
        check("reset_mid_ready", rd_ready_and_o, 1);
        check("reset_mid_data", rd_data_o, 0);
        check("reset_mid_ovf", overflow_o, 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
        do_read(3'd1, 4'd0, 0, 1'b0);
        do_read(3'd4, 4'd0, 0, 1'b0);
        snap();
        do_read(3'd3, 4'd0, 0, 1'b0);

        repeat (2) @(negedge clk_i);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_profiler_counter_bank.md
BP_PROFILER_COUNTER_BANK -- requirements
Module: bp_profiler_counter_bank

Interface
REQ-001 SHALL have parameter num_events_p, default 31, number of independent event/stall-reason counters.
REQ-002 SHALL have parameter width_p, default 64, width of every counter.
REQ-003 SHALL have parameter addr_width_lp, derived as $clog2(num_events_p+1), the read address width.
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port reset_i, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port en_i, input, 1, global count enable.
REQ-007 SHALL have port event_i, input, num_events_p, per-event increment strobes; multi-hot allowed.
REQ-008 SHALL have port clear_i, input, 1, zeroes the live counters.
REQ-009 SHALL have port snapshot_i, input, 1, copies the live bank into the shadow bank.
REQ-010 SHALL have port rd_v_i, input, 1, read request valid.
REQ-011 SHALL have port rd_addr_i, input, addr_width_lp, counter index; index num_events_p selects the cycle counter.
REQ-012 SHALL have port rd_ready_and_o, output, 1, read request accepted.
REQ-013 SHALL have port rd_data_v_o, output, 1, response valid.
REQ-014 SHALL have port rd_data_o, output, width_p, response value.
REQ-015 SHALL have port rd_yumi_i, input, 1, response consumed.
REQ-016 SHALL have port overflow_o, output, num_events_p+1, sticky per-counter overflow flags; MSB is the cycle counter.

Function
REQ-017 SHALL implement num_events_p live event counters plus one live cycle counter, each width_p bits.
REQ-018 SHALL increment live counter i by exactly 1 on each cycle where en_i=1 and event_i[i]=1.
REQ-019 SHALL increment the cycle counter on every cycle where en_i=1.
REQ-020 SHALL have clear_i zero all live counters and all overflow flags on the next edge; clear_i SHALL take priority over a same-cycle increment.
REQ-021 SHALL have snapshot_i load every shadow register with the live value held at the start of that cycle (pre-increment, pre-clear).
REQ-022 SHALL service reads from the shadow bank only.
REQ-023 SHALL implement the read FSM with two states: IDLE and RESP.
REQ-024 In IDLE, the FSM SHALL drive rd_ready_and_o=1; on rd_v_i=1 it SHALL latch shadow[rd_addr_i] (the value before any same-cycle snapshot) into rd_data_o and move to RESP.
REQ-025 In RESP, the FSM SHALL drive rd_data_v_o=1 and rd_ready_and_o=0, and SHALL hold rd_data_o stable; on rd_yumi_i=1 it SHALL return to IDLE.
REQ-026 An out-of-range address (greater than num_events_p) SHALL return 0 and SHALL still complete the handshake.
REQ-027 A wrap or saturation event SHALL set the corresponding overflow_o bit, which SHALL stay set until clear_i or reset.

Reset
REQ-028 On reset_i=1, asynchronously, the block SHALL zero all live, shadow and overflow state and rd_data_o, force the FSM to IDLE, and drive rd_data_v_o=0.
REQ-029 Reset asserted mid-handshake (in RESP) SHALL drop rd_data_v_o immediately, without waiting for rd_yumi_i.

Configuration
REQ-030 With BP_PROFILER_SATURATE_EN defined, counters SHALL saturate at all-ones, and overflow SHALL be set on the first increment attempted at all-ones.
REQ-031 Without BP_PROFILER_SATURATE_EN, counters SHALL wrap from all-ones to 0, and overflow SHALL be set on the wrap.

Structure
REQ-032 bp_profiler_pkg SHALL hold the read FSM state enum (e_rd_idle, e_rd_resp) and SHALL define the default num_events_p as the count of bp_stall_reason_e members.
REQ-033 SHALL use one sub-module, bp_profiler_counter (single counter with increment, clear, overflow and the saturate macro), instantiated num_events_p+1 times.

Verification
REQ-034 With width_p=4, event_i[2] held high for 15 cycles, en_i=1 and snapshot_i pulsed, reading addr 2 SHALL return 15 and overflow_o[2]=0.
REQ-035 With width_p=4 and 17 increments: saturate build SHALL read 15 with overflow_o[2]=1; wrap build SHALL read 1 with overflow_o[2]=1.
REQ-036 With clear_i and event_i[0] in the same cycle followed by a snapshot, addr 0 SHALL read 0 and the cycle counter SHALL read 0 plus the cycles counted after clear.
REQ-037 With rd_v_i high and rd_yumi_i held low for 5 cycles, rd_data_v_o SHALL stay 1 with stable data, rd_ready_and_o SHALL stay 0, and IDLE SHALL resume one cycle after yumi.
REQ-038 With reset_i pulsed during RESP, rd_data_v_o SHALL be 0 immediately and all reads after reset SHALL return 0.
